// File: rtl/midi_pkg.sv
// Shared definitions for the polyphonic MIDI player.
//   parse_state_e : byte parser states
//   ev_type_e     : decoded event kinds handed from parser to allocator
//   MIDI_* / CC_SUSTAIN / MIDI_OMNI : message nibbles and channel-filter value
//   sat_signed()  : clamp a signed value to a signed range of 'bits' width
package midi_pkg;

  typedef enum logic [1:0] {NO_STATUS, WAIT_D1, WAIT_D2, SKIP} parse_state_e;
  typedef enum logic [1:0] {EV_NOTE_ON, EV_NOTE_OFF, EV_CC} ev_type_e;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_CC       = 4'hB;
  localparam logic [6:0] CC_SUSTAIN    = 7'd64;
  localparam int         MIDI_OMNI     = 16;

  // Valid for bits in 2..31; callers keep the low 'bits' bits of the result.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int bits);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (bits - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/midi_byte_parser.sv
// MIDI byte-stream parser with channel filter and running status.
//   clk, rst_n            : clock, async active-low reset
//   midi_data, midi_valid : incoming byte and strobe (one byte per cycle max)
//   ev_valid              : combinational strobe on the cycle the completing
//                           data byte arrives
//   ev_type, ev_note, ev_val : event kind, first data byte, second data byte
// Macro MIDI_SUSTAIN_EN: also accept Control Change (0xBn) messages.
module midi_byte_parser
  import midi_pkg::*;
#(
  parameter int MIDI_CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] midi_data,
  input  logic       midi_valid,
  output logic       ev_valid,
  output ev_type_e   ev_type,
  output logic [6:0] ev_note,
  output logic [6:0] ev_val
);

  localparam bit OMNI = (MIDI_CHANNEL == MIDI_OMNI);

  parse_state_e state_q, state_d;
  logic [3:0]   msg_q, msg_d;
  logic [6:0]   d1_q, d1_d;

  logic       is_rt, ch_match, supported;
  logic [3:0] hi;

  assign hi       = midi_data[7:4];
  assign is_rt    = (midi_data >= 8'hF8);
  assign ch_match = OMNI || (midi_data[3:0] == 4'(MIDI_CHANNEL));

  always_comb begin
    supported = (hi == MIDI_NOTE_OFF) || (hi == MIDI_NOTE_ON);
`ifdef MIDI_SUSTAIN_EN
    supported = supported || (hi == MIDI_CC);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NO_STATUS;
      msg_q   <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      d1_q    <= d1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    d1_d     = d1_q;
    ev_valid = 1'b0;
    ev_type  = EV_NOTE_OFF;
    ev_note  = d1_q;
    ev_val   = midi_data[6:0];
    // Real-time bytes may interleave anywhere and must not disturb parsing.
    if (midi_valid && !is_rt) begin
      if (midi_data[7]) begin
        if (ch_match && supported) begin
          state_d = WAIT_D1;
          msg_d   = hi;
        end else begin
          state_d = SKIP;
        end
      end else begin
        unique case (state_q)
          WAIT_D1: begin
            d1_d    = midi_data[6:0];
            state_d = WAIT_D2;
          end
          WAIT_D2: begin
            ev_valid = 1'b1;
            state_d  = WAIT_D1;
            if (msg_q == MIDI_CC)
              ev_type = EV_CC;
            else if (msg_q == MIDI_NOTE_ON && midi_data[6:0] != 7'd0)
              ev_type = EV_NOTE_ON;
            else
              ev_type = EV_NOTE_OFF;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/midi_poly_player.sv
// Polyphonic MIDI player: parses MIDI, allocates notes over NUM_VOICES
// external voices (age-ranked stealing) and mixes their samples.
//   clk, rst_n            : clock, async active-low reset
//   midi_data/midi_valid  : raw MIDI byte stream
//   voice_gate/trig       : per-voice gate and one-cycle note-start pulse
//   voice_note/vel        : per-voice 7-bit fields, voice i at [7i+6:7i]
//   voice_sample(_valid)  : flattened signed samples from the voices
//   sound_data/valid      : saturated mix, 1 cycle after voice_sample_valid
//   active_count          : number of gated voices
// Macro MIDI_SUSTAIN_EN: sustain pedal (CC 64) support.
module midi_poly_player
  import midi_pkg::*;
#(
  parameter int NUM_VOICES   = 4,
  parameter int OUTPUT_BITS  = 16,
  parameter int MIDI_CHANNEL = 0,
  parameter int MIX_SHIFT    = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        midi_data,
  input  logic                              midi_valid,
  output logic [NUM_VOICES-1:0]             voice_gate,
  output logic [NUM_VOICES-1:0]             voice_trig,
  output logic [7*NUM_VOICES-1:0]           voice_note,
  output logic [7*NUM_VOICES-1:0]           voice_vel,
  input  logic [OUTPUT_BITS*NUM_VOICES-1:0] voice_sample,
  input  logic                              voice_sample_valid,
  output logic [OUTPUT_BITS-1:0]            sound_data,
  output logic                              sound_valid,
  output logic [3:0]                        active_count
);

  localparam int NV = NUM_VOICES;
  localparam int RW = (NV > 1) ? $clog2(NV) : 1;
  localparam int SW = OUTPUT_BITS + $clog2(NV) + 1;

  logic       ev_valid;
  ev_type_e   ev_type;
  logic [6:0] ev_note, ev_val;

  midi_byte_parser #(.MIDI_CHANNEL(MIDI_CHANNEL)) u_parser (
    .clk       (clk),
    .rst_n     (rst_n),
    .midi_data (midi_data),
    .midi_valid(midi_valid),
    .ev_valid  (ev_valid),
    .ev_type   (ev_type),
    .ev_note   (ev_note),
    .ev_val    (ev_val)
  );

  // ---------------- voice allocation ----------------
  logic [NV-1:0]         gate_q, gate_d, trig_q, trig_d;
  logic [NV-1:0][6:0]    note_q, note_d, vel_q, vel_d;
  logic [NV-1:0][RW-1:0] rank_q, rank_d;   // 0 = most recent, NV-1 = oldest
  logic [3:0]            cnt_q, cnt_d;
`ifdef MIDI_SUSTAIN_EN
  logic [NV-1:0]         sus_q, sus_d;
  logic                  pedal_q, pedal_d;
`endif

  int  hit_idx, free_idx, old_idx, ch;
  logic hit_found, free_found;

  always_comb begin
    hit_found  = 1'b0;
    free_found = 1'b0;
    hit_idx    = 0;
    free_idx   = 0;
    old_idx    = 0;
    for (int i = 0; i < NV; i++) begin
      if (!hit_found && gate_q[i] && note_q[i] == ev_note) begin
        hit_found = 1'b1;
        hit_idx   = i;
      end
      if (!free_found && !gate_q[i]) begin
        free_found = 1'b1;
        free_idx   = i;
      end
      if (rank_q[i] == RW'(NV - 1)) old_idx = i;
    end
    ch = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
  end

  always_comb begin
    gate_d = gate_q;
    trig_d = '0;
    note_d = note_q;
    vel_d  = vel_q;
    rank_d = rank_q;
`ifdef MIDI_SUSTAIN_EN
    sus_d   = sus_q;
    pedal_d = pedal_q;
`endif
    if (ev_valid) begin
      unique case (ev_type)
        EV_NOTE_ON: begin
          gate_d[ch] = 1'b1;
          trig_d[ch] = 1'b1;
          note_d[ch] = ev_note;
          vel_d[ch]  = ev_val;
`ifdef MIDI_SUSTAIN_EN
          sus_d[ch]  = 1'b0;
`endif
          // Move chosen voice to the front; everything younger ages by one.
          for (int j = 0; j < NV; j++) begin
            if (j == ch)                     rank_d[j] = '0;
            else if (rank_q[j] < rank_q[ch]) rank_d[j] = rank_q[j] + RW'(1);
          end
        end
        EV_NOTE_OFF: begin
          for (int j = 0; j < NV; j++) begin
            if (gate_q[j] && note_q[j] == ev_note) begin
`ifdef MIDI_SUSTAIN_EN
              if (pedal_q) sus_d[j]  = 1'b1;
              else         gate_d[j] = 1'b0;
`else
              gate_d[j] = 1'b0;
`endif
            end
          end
        end
`ifdef MIDI_SUSTAIN_EN
        EV_CC: begin
          if (ev_note == CC_SUSTAIN) begin
            pedal_d = ev_val[6];           // value >= 64 means pedal down
            if (!ev_val[6]) begin
              gate_d = gate_q & ~sus_q;
              sus_d  = '0;
            end
          end
        end
`endif
        default: ;
      endcase
    end
    cnt_d = '0;
    for (int i = 0; i < NV; i++) cnt_d = cnt_d + 4'(gate_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
      trig_q <= '0;
      note_q <= '0;
      vel_q  <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NV; i++) rank_q[i] <= RW'(i);
    end else begin
      gate_q <= gate_d;
      trig_q <= trig_d;
      note_q <= note_d;
      vel_q  <= vel_d;
      cnt_q  <= cnt_d;
      rank_q <= rank_d;
    end
  end

`ifdef MIDI_SUSTAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sus_q   <= '0;
      pedal_q <= 1'b0;
    end else begin
      sus_q   <= sus_d;
      pedal_q <= pedal_d;
    end
  end
`endif

  assign voice_gate   = gate_q;
  assign voice_trig   = trig_q;
  assign voice_note   = note_q;
  assign voice_vel    = vel_q;
  assign active_count = cnt_q;

  // ---------------- mixer ----------------
  logic signed [SW-1:0] sum, sum_sh;
  logic signed [31:0]   sat_v;
  logic                 unused_sat_hi;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NV; i++)
      sum = sum + SW'($signed(voice_sample[i*OUTPUT_BITS +: OUTPUT_BITS]));
    sum_sh = sum >>> MIX_SHIFT;
    sat_v  = sat_signed(32'(sum_sh), OUTPUT_BITS);
  end

  assign unused_sat_hi = ^sat_v[31:OUTPUT_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sound_data  <= '0;
      sound_valid <= 1'b0;
    end else begin
      sound_valid <= voice_sample_valid;
      if (voice_sample_valid) sound_data <= sat_v[OUTPUT_BITS-1:0];
    end
  end

endmodule

// File: tb/tb_midi_poly_player.sv
// Scoreboard bench for midi_poly_player: random MIDI and sample traffic
// against a behavioural model (timestamp ages, running-status parser).
module tb_midi_poly_player;

  localparam int NV = 4;
  localparam int OB = 16;
  localparam int SH = 1;
`ifdef MIDI_SUSTAIN_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [7:0]        midi_data = '0;
  logic              midi_valid = 1'b0;
  logic [NV-1:0]     voice_gate, voice_trig;
  logic [7*NV-1:0]   voice_note, voice_vel;
  logic [OB*NV-1:0]  voice_sample = '0;
  logic              voice_sample_valid = 1'b0;
  logic [OB-1:0]     sound_data;
  logic              sound_valid;
  logic [3:0]        active_count;

  always #5 clk = ~clk;

  midi_poly_player #(.NUM_VOICES(NV), .OUTPUT_BITS(OB), .MIDI_CHANNEL(0), .MIX_SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .midi_data(midi_data), .midi_valid(midi_valid),
    .voice_gate(voice_gate), .voice_trig(voice_trig), .voice_note(voice_note),
    .voice_vel(voice_vel), .voice_sample(voice_sample),
    .voice_sample_valid(voice_sample_valid), .sound_data(sound_data),
    .sound_valid(sound_valid), .active_count(active_count)
  );

  int tests = 0, fails = 0, cyc = 0;
  logic byte_seen = 1'b0;
  bit mon_on = 1'b0;
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    byte_seen <= midi_valid && rst_n;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [NV-1:0]   gate, trig;
    logic [7*NV-1:0] note, vel;
    logic [3:0]      cnt;
  } snap_t;
  typedef struct { int val; int at; } mix_t;
  snap_t snap_q[$];
  mix_t  mix_q[$];

  bit m_gate[NV], m_trig[NV], m_sus[NV], m_pedal, have_d1;
  int m_note[NV], m_vel[NV], m_stamp[NV], tick, rs, d1;

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 0; m_trig[i] = 0; m_sus[i] = 0;
      m_note[i] = 0; m_vel[i] = 0; m_stamp[i] = -i;  // higher index = older
    end
    m_pedal = 0; tick = 0; rs = -1; have_d1 = 0;
  endtask

  task automatic model_event(input int kind, input int a, input int b);
    int c;
    if (kind == 9 && b != 0) begin
      c = -1;
      for (int i = 0; i < NV; i++) if (c < 0 && m_gate[i] && m_note[i] == a) c = i;
      for (int i = 0; i < NV; i++) if (c < 0 && !m_gate[i]) c = i;
      if (c < 0) begin
        c = 0;
        for (int i = 1; i < NV; i++) if (m_stamp[i] < m_stamp[c]) c = i;
      end
      tick++;
      m_stamp[c] = tick; m_gate[c] = 1; m_trig[c] = 1;
      m_note[c] = a; m_vel[c] = b; m_sus[c] = 0;
    end else if (kind == 8 || kind == 9) begin
      for (int i = 0; i < NV; i++)
        if (m_gate[i] && m_note[i] == a) begin
          if (m_pedal) m_sus[i] = 1; else m_gate[i] = 0;
        end
    end else if (kind == 11 && a == 64) begin
      m_pedal = (b >= 64);
      if (!m_pedal)
        for (int i = 0; i < NV; i++) if (m_sus[i]) begin m_gate[i] = 0; m_sus[i] = 0; end
    end
  endtask

  task automatic model_byte(input int b);
    snap_t s;
    int hi;
    for (int i = 0; i < NV; i++) m_trig[i] = 0;
    if (b >= 'hF8) begin
    end else if (b >= 'h80) begin
      hi = b >> 4;
      have_d1 = 0;
      if ((b & 15) == 0 && (hi == 8 || hi == 9 || (CC_EN && hi == 11))) rs = hi;
      else rs = -1;
    end else if (rs >= 0) begin
      if (!have_d1) begin d1 = b; have_d1 = 1; end
      else begin have_d1 = 0; model_event(rs, d1, b); end
    end
    s.cnt = 0;
    for (int i = 0; i < NV; i++) begin
      s.gate[i] = m_gate[i];
      s.trig[i] = m_trig[i];
      s.note[7*i +: 7] = 7'(m_note[i]);
      s.vel[7*i +: 7]  = 7'(m_vel[i]);
      s.cnt = s.cnt + 4'(m_gate[i]);
    end
    snap_q.push_back(s);
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    midi_data  = b;
    midi_valid = 1'b1;
    model_byte(int'(b));
  endtask

  task automatic midi_idle();
    @(negedge clk);
    midi_valid = 1'b0;
  endtask

  task automatic mix_strobe(input logic [OB*NV-1:0] smp);
    mix_t e;
    int sum;
    @(negedge clk);
    voice_sample       = smp;
    voice_sample_valid = 1'b1;
    sum = 0;
    for (int i = 0; i < NV; i++) sum += int'($signed(smp[i*OB +: OB]));
    sum = sum >>> SH;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    e.val = sum;
    e.at  = cyc + 1;
    mix_q.push_back(e);
  endtask

  task automatic send_seq(input logic [7:0] seq[]);
    foreach (seq[k]) send_byte(seq[k]);
    midi_idle();
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 8)  return 8'h90;
    if (r < 12) return 8'h80;
    if (r < 14) return 8'h91;
    if (r < 16) return 8'hE0;
    if (r < 18) return 8'hF8;
    if (r < 20) return 8'hF0;
    if (r < 24) return 8'hB0;
    if (r < 60) return 8'(8'h3C + $urandom_range(0, 7));
    if (r < 66) return 8'h00;
    if (r < 72) return 8'h40;
    return 8'($urandom_range(0, 127));
  endfunction

  // ---------------- monitor ----------------
  snap_t s_m;
  mix_t  e_m;
  always @(negedge clk) begin
    if (mon_on) begin
      if (byte_seen) begin
        if (snap_q.size() == 0) chk("voice_snapshot_missing", 1, 0);
        else begin
          s_m = snap_q.pop_front();
          chk("voice_gate", voice_gate, s_m.gate);
          chk("voice_trig", voice_trig, s_m.trig);
          chk("voice_note", voice_note, s_m.note);
          chk("voice_vel", voice_vel, s_m.vel);
          chk("active_count", active_count, s_m.cnt);
        end
      end else begin
        chk("voice_trig_idle", voice_trig, 0);
      end
      if (sound_valid) begin
        if (mix_q.size() == 0) chk("sound_valid_spurious", 1, 0);
        else begin
          e_m = mix_q.pop_front();
          chk("sound_data", longint'($signed(sound_data)), longint'(e_m.val));
          chk("sound_latency", cyc, e_m.at);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_gate", voice_gate, 0);
    chk("reset_trig", voice_trig, 0);
    chk("reset_note", voice_note, 0);
    chk("reset_count", active_count, 0);
    chk("reset_sound_valid", sound_valid, 0);
    chk("reset_sound_data", sound_data, 0);
    mon_on = 1'b1;

    send_seq('{8'h90, 8'h3C, 8'h64});
    send_seq('{8'h90, 8'h3C, 8'h64, 8'h40, 8'h64, 8'h43, 8'h64, 8'h48, 8'h64, 8'h4C, 8'h64});
    send_seq('{8'h90, 8'h40, 8'hF8, 8'h00});
    send_seq('{8'h91, 8'h3C, 8'h64});
    send_seq('{8'hE0, 8'h00, 8'h40, 8'h3C});
    send_seq('{8'hB0, 8'h40, 8'h7F, 8'h90, 8'h3C, 8'h64, 8'h80, 8'h3C, 8'h00});
    send_seq('{8'hB0, 8'h40, 8'h00});

    mix_strobe({NV{16'h7000}});
    mix_strobe({NV{16'h9000}});
    mix_strobe({16'h0001, 16'h0002, 16'hFFFF, 16'h0000});
    @(negedge clk) voice_sample_valid = 1'b0;

    fork
      begin
        for (int k = 0; k < 500; k++) begin
          send_byte(rand_byte());
          if ($urandom_range(0, 3) == 0) midi_idle();
        end
        midi_idle();
      end
      begin
        for (int k = 0; k < 200; k++) begin
          logic [OB*NV-1:0] smp;
          for (int i = 0; i < NV; i++)
            smp[i*OB +: OB] = ($urandom_range(0, 4) == 0) ?
                              (($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000) :
                              16'($urandom);
          mix_strobe(smp);
          if ($urandom_range(0, 2) == 0) @(negedge clk) voice_sample_valid = 1'b0;
        end
        @(negedge clk) voice_sample_valid = 1'b0;
      end
    join

    // Asynchronous reset in the middle of a pending message.
    send_seq('{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C});
    chk("pre_reset_gate_nonzero", (voice_gate != 0), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_gate", voice_gate, 0);
    chk("async_reset_count", active_count, 0);
    chk("async_reset_note", voice_note, 0);
    model_reset();
    snap_q.delete();
    @(negedge clk) rst_n = 1'b1;

    // Parser restarts in NO_STATUS: stray data is dropped, then voice 0 allocates.
    send_seq('{8'h3C, 8'h64, 8'h90, 8'h45, 8'h7F});
    repeat (3) @(negedge clk);
    chk("voice_queue_drained", snap_q.size(), 0);
    chk("mix_queue_drained", mix_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
